// File: rtl/aes_key_expand.sv
// aes_key_expand -- iterative AES key schedule for 128/192/256-bit keys.
//
// Produces one 32-bit schedule word per clock after a start request and
// presents all round keys at once on key_words_o.
//
// Ports
//   eph1         clock; every register updates on its rising edge
//   reset        synchronous active-low reset
//   start        one-cycle expansion request, honoured in IDLE or DONE only
//   key_size_i   00 = 128-bit, 01 = 192-bit, 1x = 256-bit (captured with start)
//   key_i        left-justified cipher key (captured with start)
//   key_words_o  round keys; [15] = round key 0, [15-r] = round key r
//   ready_o      key_words_o is complete for the captured key size
//   busy_o       expansion in progress
//
// Handshake: start is a single-cycle request with no back-pressure. It is
// accepted on any edge where busy_o=0 and reset=1. key_words_o is meaningful
// only while ready_o=1, and it stays frozen until the next accepted start or
// the next reset.
module aes_key_expand (
  input  logic                 eph1,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           key_size_i,
  input  logic [255:0]         key_i,
  output logic [15:1][127:0]   key_words_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  // Schedule words w0..w59. With word 0 at the most-significant end, this
  // vector has the same bit layout as key_words_o. Round key r is words
  // 4r..4r+3, and word 4r+c sits at bits [127-32c -: 32] of slot 15-r.
  logic [0:59][31:0] words;
  logic [0:59][31:0] init_words;

  logic [5:0] idx;       // index i of the next word to be produced
  logic [7:0] rcon;
  logic [2:0] mod_cnt;   // i mod Nk, kept by a wrapping counter
  logic [1:0] size_q;

  logic [3:0]  nk;
  logic [3:0]  nk_in;
  logic [5:0]  last_idx;
  logic        start_ok;
  logic [31:0] prev_word;
  logic [31:0] base_word;
  logic [31:0] temp_word;
  logic [31:0] new_word;

  function automatic logic [3:0] nk_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // AES S-box: the multiplicative inverse is x^254, built as the product of
  // x^2, x^4 ... x^128. The affine transform is applied afterwards.
  // 0 maps to 0 before the affine step, as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb begin
    nk       = nk_of(size_q);
    nk_in    = nk_of(key_size_i);
    case (size_q)
      2'b00:   last_idx = 6'd43;
      2'b01:   last_idx = 6'd51;
      default: last_idx = 6'd59;
    endcase
    start_ok = start && ((state == IDLE) || (state == DONE));

    prev_word = words[idx - 6'd1];
    base_word = words[idx - {2'b00, nk}];
    if (mod_cnt == 3'd0)
      temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
    else if ((nk == 4'd8) && (mod_cnt == 3'd4))
      temp_word = sub_word(prev_word);
    else
      temp_word = prev_word;
    new_word = base_word ^ temp_word;

    // Words w0..w(Nk-1) come from the key, MSB first. Every other slot
    // starts at zero, so the unused tail reads 0 when ready_o is high.
    init_words = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(nk_in)) init_words[k] = key_i[255-32*k -: 32];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (idx == last_idx) state_next = DONE;
      DONE:    if (start) state_next = EXPAND;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge eph1) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge eph1) begin
    if (!reset) begin
      words   <= '0;
      idx     <= 6'd0;
      rcon    <= 8'h00;
      mod_cnt <= 3'd0;
      size_q  <= 2'b00;
    end else if (start_ok) begin
      words   <= init_words;
      size_q  <= key_size_i;
      idx     <= {2'b00, nk_in};
      rcon    <= 8'h01;
      mod_cnt <= 3'd0;
    end else if (state == EXPAND) begin
      words[idx] <= new_word;
      idx        <= idx + 6'd1;
      if (mod_cnt == 3'd0) rcon <= xtime(rcon);
      if (mod_cnt == 3'(nk - 4'd1)) mod_cnt <= 3'd0;
      else                          mod_cnt <= mod_cnt + 3'd1;
    end
  end

  assign key_words_o = words;
  assign ready_o     = (state == DONE);
  assign busy_o      = (state == EXPAND);

endmodule
